// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rr_arbiter
// Brief    : Two-port round-robin front end sharing one single-port RAM array.
// Revision : 1.0  initial release
// ============================================================================
module ram_rr_arbiter #(
   parameter int N = 6,
   parameter int M = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic         req0_we,
   input  logic [N-1:0] req0_addr,
   input  logic [M-1:0] req0_wdata,
   output logic         resp0_valid,
   output logic [M-1:0] resp0_rdata,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic         req1_we,
   input  logic [N-1:0] req1_addr,
   input  logic [M-1:0] req1_wdata,
   output logic         resp1_valid,
   output logic [M-1:0] resp1_rdata
);

   localparam int c_DEPTH = 2 ** N;

   logic [M-1:0] r_ram [c_DEPTH];
   logic         r_last_grant;
   logic         r_resp0_valid;
   logic         r_resp1_valid;
   logic [M-1:0] r_resp0_rdata;
   logic [M-1:0] r_resp1_rdata;

   logic         w_grant0;
   logic         w_grant1;
   logic         w_ram_we;
   logic [N-1:0] w_ram_addr;
   logic [M-1:0] w_ram_din;
   logic [M-1:0] w_ram_dout;

   // On a tie the port that did not win the last handshake is served.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant0 = r_last_grant;
         w_grant1 = ~r_last_grant;
      end else begin
         w_grant0 = req0_valid;
         w_grant1 = req1_valid;
      end
   end

   always_comb begin
      w_ram_we   = 1'b0;
      w_ram_addr = req0_addr;
      w_ram_din  = req0_wdata;
      if (w_grant1) begin
         w_ram_we   = req1_we;
         w_ram_addr = req1_addr;
         w_ram_din  = req1_wdata;
      end else if (w_grant0) begin
         w_ram_we   = req0_we;
      end
   end

   // Single-port array: synchronous write, asynchronous read; never reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_ram[w_ram_addr] <= w_ram_din;
      end
   end

   assign w_ram_dout = r_ram[w_ram_addr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_grant  <= 1'b1;
         r_resp0_valid <= 1'b0;
         r_resp1_valid <= 1'b0;
         r_resp0_rdata <= '0;
         r_resp1_rdata <= '0;
      end else begin
         if (w_grant0) begin
            r_last_grant <= 1'b0;
         end else if (w_grant1) begin
            r_last_grant <= 1'b1;
         end
         r_resp0_valid <= w_grant0 & ~req0_we;
         r_resp1_valid <= w_grant1 & ~req1_we;
         if (w_grant0 && !req0_we) begin
            r_resp0_rdata <= w_ram_dout;
         end
         if (w_grant1 && !req1_we) begin
            r_resp1_rdata <= w_ram_dout;
         end
      end
   end

   assign req0_ready  = w_grant0;
   assign req1_ready  = w_grant1;
   assign resp0_valid = r_resp0_valid;
   assign resp1_valid = r_resp1_valid;
   assign resp0_rdata = r_resp0_rdata;
   assign resp1_rdata = r_resp1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rr_arbiter
// Brief    : Directed self-checking bench for ram_rr_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_rr_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid, req0_ready, req0_we, resp0_valid;
   logic [5:0]  req0_addr;
   logic [31:0] req0_wdata, resp0_rdata;
   logic        req1_valid, req1_ready, req1_we, resp1_valid;
   logic [5:0]  req1_addr;
   logic [31:0] req1_wdata, resp1_rdata;

   int total = 0;
   int bad   = 0;

   ram_rr_arbiter #(.N(6), .M(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_we     (req0_we),
      .req0_addr   (req0_addr),
      .req0_wdata  (req0_wdata),
      .resp0_valid (resp0_valid),
      .resp0_rdata (resp0_rdata),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_we     (req1_we),
      .req1_addr   (req1_addr),
      .req1_wdata  (req1_wdata),
      .resp1_valid (resp1_valid),
      .resp1_rdata (resp1_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive0(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
   endtask

   task automatic drive1(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k0, k1, hs0, hs1;
      logic rd0, rd1;
      logic [31:0] exp0, exp1;

      reset = 1'b0;
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b0, 1'b0, 6'd0, 32'h0);
      #12;
      check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
      check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
      check("rst_resp0_rdata", resp0_rdata, 32'd0);
      check("rst_resp1_rdata", resp1_rdata, 32'd0);
      step();
      reset = 1'b1;

      // Write then read back on port 0.
      drive0(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
      #2 check("wr5_ready0", 32'(req0_ready), 32'd1);
      check("wr5_ready1", 32'(req1_ready), 32'd0);
      step();
      check("wr5_no_resp", 32'(resp0_valid), 32'd0);
      drive0(1'b1, 1'b0, 6'd5, 32'h0);
      #2 check("rd5_ready0", 32'(req0_ready), 32'd1);
      step();
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      check("rd5_valid", 32'(resp0_valid), 32'd1);
      check("rd5_data", resp0_rdata, 32'hDEADBEEF);
      check("rd5_resp1", 32'(resp1_valid), 32'd0);
      step();
      check("rd5_pulse_end", 32'(resp0_valid), 32'd0);
      check("rd5_hold", resp0_rdata, 32'hDEADBEEF);

      // Preload, reset, then simultaneous reads: port 0 must win first.
      drive0(1'b1, 1'b1, 6'd1, 32'h11);
      step();
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b1, 1'b1, 6'd2, 32'h22);
      step();
      drive1(1'b0, 1'b0, 6'd0, 32'h0);
      reset = 1'b0;
      #2 reset = 1'b1;
      drive0(1'b1, 1'b0, 6'd1, 32'h0);
      drive1(1'b1, 1'b0, 6'd2, 32'h0);
      #1 check("tie_ready0", 32'(req0_ready), 32'd1);
      check("tie_ready1", 32'(req1_ready), 32'd0);
      step();
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      check("tie_resp0_valid", 32'(resp0_valid), 32'd1);
      check("tie_resp0_data", resp0_rdata, 32'h11);
      check("tie_resp1_idle", 32'(resp1_valid), 32'd0);
      #2 check("tie2_ready1", 32'(req1_ready), 32'd1);
      step();
      drive1(1'b0, 1'b0, 6'd0, 32'h0);
      check("tie2_resp1_valid", 32'(resp1_valid), 32'd1);
      check("tie2_resp1_data", resp1_rdata, 32'h22);
      check("tie2_resp0_idle", 32'(resp0_valid), 32'd0);

      // Eight cycles of contention: even transactions write, odd read back.
      k0 = 0; k1 = 0; hs0 = 0; hs1 = 0;
      for (int i = 0; i < 8; i++) begin
         drive0(1'b1, (k0 % 2) == 0, 6'(20 + k0 / 2), 32'h100 + 32'(k0));
         drive1(1'b1, (k1 % 2) == 0, 6'(40 + k1 / 2), 32'h200 + 32'(k1));
         #2;
         check($sformatf("alt%0d_ready0", i), 32'(req0_ready), 32'((i % 2) == 0));
         check($sformatf("alt%0d_ready1", i), 32'(req1_ready), 32'((i % 2) == 1));
         hs0 += int'(req0_ready);
         hs1 += int'(req1_ready);
         rd0 = 1'b0; rd1 = 1'b0; exp0 = '0; exp1 = '0;
         if ((i % 2) == 0) begin
            rd0  = (k0 % 2) == 1;
            exp0 = 32'h100 + 32'(k0 - 1);
            k0++;
         end else begin
            rd1  = (k1 % 2) == 1;
            exp1 = 32'h200 + 32'(k1 - 1);
            k1++;
         end
         step();
         check($sformatf("alt%0d_resp0_valid", i), 32'(resp0_valid), 32'(rd0));
         check($sformatf("alt%0d_resp1_valid", i), 32'(resp1_valid), 32'(rd1));
         if (rd0) check($sformatf("alt%0d_resp0_data", i), resp0_rdata, exp0);
         if (rd1) check($sformatf("alt%0d_resp1_data", i), resp1_rdata, exp1);
      end
      check("alt_hs0", 32'(hs0), 32'd4);
      check("alt_hs1", 32'(hs1), 32'd4);
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b0, 1'b0, 6'd0, 32'h0);

      // Same-cycle write (port 1) and read (port 0) of addr 63 after a port 0 grant.
      drive0(1'b1, 1'b1, 6'd63, 32'h12345678);
      step();
      drive0(1'b1, 1'b0, 6'd63, 32'h0);
      drive1(1'b1, 1'b1, 6'd63, 32'hA5A5A5A5);
      #2 check("raw_ready1", 32'(req1_ready), 32'd1);
      check("raw_ready0", 32'(req0_ready), 32'd0);
      step();
      drive1(1'b0, 1'b0, 6'd0, 32'h0);
      #2 check("raw_ready0_next", 32'(req0_ready), 32'd1);
      step();
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      check("raw_resp0_valid", 32'(resp0_valid), 32'd1);
      check("raw_resp0_data", resp0_rdata, 32'hA5A5A5A5);

      // Reset right after a read handshake drops the response pulse.
      drive1(1'b1, 1'b1, 6'd10, 32'hCAFE0010);
      step();
      drive1(1'b0, 1'b0, 6'd0, 32'h0);
      drive0(1'b1, 1'b0, 6'd10, 32'h0);
      step();
      reset = 1'b0;
      #1 check("mid_rst_resp0_valid", 32'(resp0_valid), 32'd0);
      check("mid_rst_resp0_data", resp0_rdata, 32'd0);
      #1 reset = 1'b1;
      drive0(1'b1, 1'b0, 6'd10, 32'h0);
      drive1(1'b1, 1'b0, 6'd5, 32'h0);
      #1 check("post_rst_ready0", 32'(req0_ready), 32'd1);
      check("post_rst_ready1", 32'(req1_ready), 32'd0);
      step();
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b0, 1'b0, 6'd0, 32'h0);
      check("post_rst_resp0_valid", 32'(resp0_valid), 32'd1);
      check("post_rst_resp0_data", resp0_rdata, 32'hCAFE0010);

      // Idle cycles: nothing granted, nothing returned, priority preserved.
      for (int i = 0; i < 3; i++) begin
         #2;
         check($sformatf("idle%0d_ready0", i), 32'(req0_ready), 32'd0);
         check($sformatf("idle%0d_ready1", i), 32'(req1_ready), 32'd0);
         step();
         check($sformatf("idle%0d_resp0", i), 32'(resp0_valid), 32'd0);
         check($sformatf("idle%0d_resp1", i), 32'(resp1_valid), 32'd0);
      end
      drive0(1'b1, 1'b0, 6'd5, 32'h0);
      drive1(1'b1, 1'b0, 6'd10, 32'h0);
      #2 check("idle_tie_ready1", 32'(req1_ready), 32'd1);
      check("idle_tie_ready0", 32'(req0_ready), 32'd0);
      step();
      drive1(1'b0, 1'b0, 6'd0, 32'h0);
      check("idle_tie_resp1_data", resp1_rdata, 32'hCAFE0010);
      check("idle_tie_resp1_valid", 32'(resp1_valid), 32'd1);
      #2 check("idle_tie_ready0_next", 32'(req0_ready), 32'd1);
      step();
      drive0(1'b0, 1'b0, 6'd0, 32'h0);
      check("idle_ram_kept", resp0_rdata, 32'hDEADBEEF);
      check("idle_ram_valid", 32'(resp0_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
